// File: rtl/operand_fetch.sv
// Operand-fetch stage: issues regfile reads, tracks in-flight destinations in a busy
// scoreboard and stalls RAW hazards. Optional stall counter under OPFETCH_STALL_CNT_EN.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [4:0]        rf_addr_a,
    output logic [4:0]        rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [TAG_W-1:0]  out_tag
`ifdef OPFETCH_STALL_CNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [31:0]       busy;
    logic [31:0]       busy_next;
    logic [31:0]       busy_set;
    logic [31:0]       busy_clr;
    logic [DATA_W-1:0] skid_a;
    logic [DATA_W-1:0] skid_b;
    logic              haz_a;
    logic              haz_b;
    logic              accept;

    assign rf_addr_a = in_rs1;
    assign rf_addr_b = in_rs2;

    // A writeback in this cycle resolves the hazard because the regfile forwards it.
    assign haz_a    = busy[in_rs1] && !(wb_valid && (wb_rd == in_rs1));
    assign haz_b    = busy[in_rs2] && !(wb_valid && (wb_rd == in_rs2));
    assign in_ready = !haz_a && !haz_b &&
                      ((state == IDLE) || ((state == READ) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        busy_clr  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
        busy_set  = (accept && in_rd_we && (in_rd != 5'd0)) ? (32'd1 << in_rd) : 32'd0;
        busy_next = (busy & ~busy_clr) | busy_set;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        next_state = state;
        out_valid  = 1'b0;
        out_op_a   = rf_data_a;
        out_op_b   = rf_data_b;
        case (state)
            IDLE: begin
                if (accept) next_state = READ;
            end
            READ: begin
                out_valid = 1'b1;
                if (out_ready) next_state = accept ? READ : IDLE;
                else           next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                out_op_a  = skid_a;
                out_op_b  = skid_b;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state     <= IDLE;
            busy      <= '0;
            // NOTE: the skid pair is two plain registers, so it is cleared with the rest.
            skid_a    <= '0;
            skid_b    <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_tag   <= '0;
        end else begin
            state <= next_state;
            busy  <= busy_next;
            // Regfile data is only valid for one cycle, so park it when execute stalls.
            if ((state == READ) && !out_ready) begin
                skid_a <= rf_data_a;
                skid_b <= rf_data_b;
            end
            if (accept) begin
                out_rd    <= in_rd;
                out_rd_we <= in_rd_we;
                out_tag   <= in_tag;
            end
        end
    end

`ifdef OPFETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                           stall_count <= '0;
        else if (in_valid && (haz_a || haz_b)) stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: behavioural 2R/1W regfile with forwarding and a
// queue of expected operand bundles popped on every output transfer.
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [31:0] in_tag;
    logic [4:0]  rf_addr_a;
    logic [4:0]  rf_addr_b;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_tag;
`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    logic [31:0] regs [32];
    exp_t        exp_q[$];
    exp_t        pend;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          n_mark;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(32), .TAG_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .in_tag    (in_tag),
        .rf_addr_a (rf_addr_a),
        .rf_addr_b (rf_addr_b),
        .rf_data_a (rf_data_a),
        .rf_data_b (rf_data_b),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op_a  (out_op_a),
        .out_op_b  (out_op_b),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we),
        .out_tag   (out_tag)
`ifdef OPFETCH_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    function automatic logic [31:0] init_val(int i);
        case (i)
            0:       return 32'h0;
            1:       return 32'd5;
            2:       return 32'd7;
            default: return 32'(i * 'h11);
        endcase
    endfunction

    // Regfile model: 1-cycle synchronous read with same-cycle write forwarding.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
            rf_data_a <= '0;
            rf_data_b <= '0;
        end else begin
            rf_data_a <= (wb_valid && wb_rd == rf_addr_a && wb_rd != 0) ? wb_data : regs[rf_addr_a];
            rf_data_b <= (wb_valid && wb_rd == rf_addr_b && wb_rd != 0) ? wb_data : regs[rf_addr_b];
            if (wb_valid && wb_rd != 0) regs[wb_rd] <= wb_data;
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                          logic we, logic [31:0] tag, logic [31:0] ea, logic [31:0] eb);
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
        in_tag   = tag;
        pend     = '{a: ea, b: eb, rd: rd, we: we, tag: tag};
    endtask

    // Called just after a negedge with inputs driven; retires an output transfer,
    // records an accepted instruction, then advances one clock.
    task automatic step();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_op_a", out_op_a, e.a);
                check("out_op_b", out_op_b, e.b);
                check("out_tag", out_tag, e.tag);
                check("out_rd", 32'(out_rd), 32'(e.rd));
                check("out_rd_we", 32'(out_rd_we), 32'(e.we));
                n_out++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(pend);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        wb_valid = 1'b0;
        wb_rd = '0;
        wb_data = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_tag", out_tag, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_rd_we", 32'(out_rd_we), 32'd0);

        // Basic fetch, one-cycle latency
        set_in(1, 1, 2, 4, 0, 32'h1000, 5, 7);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("latency_valid", 32'(out_valid), 32'd1);
        step();
        #1 check("idle_after_xfer", 32'(out_valid), 32'd0);

        // RAW hazard resolved by a same-cycle writeback
        set_in(1, 0, 0, 3, 1, 32'h2000, 0, 0);
        step();
        set_in(1, 3, 1, 6, 0, 32'h2004, 32'h99, 5);
        #1 check("raw_stall0", 32'(in_ready), 32'd0);
        step();
        #1 check("raw_stall1", 32'(in_ready), 32'd0);
        step();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h99;
        #1 check("raw_wb_accept", 32'(in_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        set_in(1, 3, 0, 0, 0, 32'h2008, 32'h99, 0);
        #1 check("busy3_cleared", 32'(in_ready), 32'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Set and clear of the same register in one cycle: set wins
        set_in(1, 0, 0, 7, 1, 32'h2100, 0, 0);
        step();
        set_in(1, 0, 0, 7, 1, 32'h2104, 0, 0);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h7A;
        #1 check("setclr_accept", 32'(in_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        set_in(1, 7, 0, 0, 0, 32'h2108, 32'h7B, 0);
        #1 check("set_wins_stall", 32'(in_ready), 32'd0);
        step();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h7B;
        #1 check("set_wins_release", 32'(in_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Backpressure: three cycles of out_ready=0, regfile data changing underneath
        set_in(1, 1, 2, 5, 1, 32'h3000, 5, 7);
        step();
        out_ready = 1'b0;
        set_in(1, 4, 6, 0, 0, 32'h3004, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_op_a", out_op_a, 32'd5);
            check("hold_op_b", out_op_b, 32'd7);
            check("hold_tag", out_tag, 32'h3000);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        n_mark = n_out;
        step();
        check("hold_one_xfer", 32'(n_out - n_mark), 32'd1);
        #1 check("hold_release_idle", 32'(out_valid), 32'd0);

        // Reset while holding with busy[5] set
        set_in(1, 1, 2, 8, 1, 32'h4000, 5, 7);
        step();
        out_ready = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1 check("pre_rst_hold", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        set_in(1, 5, 0, 0, 0, 32'h4004, 32'h55, 0);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_tag", out_tag, 32'd0);
        check("midrst_busy_clear", 32'(in_ready), 32'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // x0 is never busy; then back-to-back independent instructions
        set_in(1, 1, 2, 0, 1, 32'h5000, 5, 7);
        step();
        set_in(1, 0, 0, 9, 0, 32'h5004, 0, 0);
        #1 check("x0_no_stall", 32'(in_ready), 32'd1);
        step();
        n_mark = n_out;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 2, 5'(10 + i), 0, 32'h6000 + 32'(4 * i), 5, 7);
            #1;
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("b2b_xfer_count", 32'(n_out - n_mark), 32'd5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef OPFETCH_STALL_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 check("stall_cnt_rst", stall_count, 32'd0);
        set_in(1, 0, 0, 10, 1, 32'h7000, 0, 0);
        step();
        set_in(1, 10, 0, 0, 0, 32'h7004, 32'h1A, 0);
        repeat (4) step();
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h1A;
        #1;
        check("stall_cnt_4", stall_count, 32'd4);
        check("stall_release", 32'(in_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("stall_queue_drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
